// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP controller-sequencer.
//   - opcode constants (4-bit instruction-register upper nibble)
//   - ALU select encoding carried on su[1:0]
//   - one-hot T-state encodings (bit0 = T1) and the HALT encoding (all zero)
//   - alu_sel(): maps an ALU opcode to its su value
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [1:0] {
    SU_ADD = 2'd0,
    SU_SUB = 2'd1,
    SU_AND = 2'd2,
    SU_OR  = 2'd3
  } su_e;

  localparam logic [5:0] T1_OH  = 6'b000001;
  localparam logic [5:0] T2_OH  = 6'b000010;
  localparam logic [5:0] T3_OH  = 6'b000100;
  localparam logic [5:0] T4_OH  = 6'b001000;
  localparam logic [5:0] T5_OH  = 6'b010000;
  localparam logic [5:0] T6_OH  = 6'b100000;
  localparam logic [5:0] T_HALT = 6'b000000;

  typedef enum logic [5:0] {
    ST_HALT = T_HALT,
    ST_T1   = T1_OH,
    ST_T2   = T2_OH,
    ST_T3   = T3_OH,
    ST_T4   = T4_OH,
    ST_T5   = T5_OH,
    ST_T6   = T6_OH
  } t_state_e;

  function automatic su_e alu_sel(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_sel = SU_SUB;
      OP_AND:  alu_sel = SU_AND;
      OP_OR:   alu_sel = SU_OR;
      default: alu_sel = SU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/sap_controller_if.sv
// sap_controller_if: control-word bundle between the SAP sequencer and the datapath.
//   opcode  : IR upper nibble, driven by the datapath (valid from T4)
//   t_state : one-hot ring state, bit0 = T1, all zero in HALT
//   cp ep lm ce li ei la ea lb eu lo : PC/MAR/RAM/IR/A/B/ALU/OUT strobes
//   su      : ALU select (0 ADD, 1 SUB, 2 AND, 3 OR)
//   halted  : high while halted (and combinationally in T4 of HLT)
// master = controller side, slave = datapath side.
interface sap_controller_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic [5:0]          t_state;
  logic                cp;
  logic                ep;
  logic                lm;
  logic                ce;
  logic                li;
  logic                ei;
  logic                la;
  logic                ea;
  logic                lb;
  logic [1:0]          su;
  logic                eu;
  logic                lo;
  logic                halted;

  modport master (
    input  opcode,
    output t_state, cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, halted
  );

  modport slave (
    output opcode,
    input  t_state, cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, halted
  );
endinterface

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: one-hot T1..T6 ring with a sticky HALT state.
//   clk, clr   : clock, asynchronous active-high reset (forces T1)
//   halt_req   : enter HALT on the next edge (only raised in T4)
//   wrap_early : return to T1 on the next edge (only with SAP_VARIABLE_CYCLE_EN)
//   t_state    : one-hot state, bit0 = T1, zero in HALT
//   halted     : registered HALT flag
// Build option: SAP_VARIABLE_CYCLE_EN adds the wrap_early input.
import sap_pkg::*;

module sap_ring_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       halt_req,
`ifdef SAP_VARIABLE_CYCLE_EN
  input  logic       wrap_early,
`endif
  output logic [5:0] t_state,
  output logic       halted
);

  t_state_e st;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st <= ST_T1;
    end else if (st == ST_HALT) begin
      // only clr leaves HALT
      st <= ST_HALT;
    end else if (halt_req) begin
      st <= ST_HALT;
`ifdef SAP_VARIABLE_CYCLE_EN
    end else if (wrap_early) begin
      st <= ST_T1;
`endif
    end else begin
      case (st)
        ST_T1:   st <= ST_T2;
        ST_T2:   st <= ST_T3;
        ST_T3:   st <= ST_T4;
        ST_T4:   st <= ST_T5;
        ST_T5:   st <= ST_T6;
        default: st <= ST_T1;
      endcase
    end
  end

  assign t_state = st;
  assign halted  = (st == ST_HALT);

endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP controller-sequencer; ring counter plus opcode decoder.
//   clk, clr : clock, asynchronous active-high reset (machine restarts at T1)
//   bus      : sap_controller_if.master -- opcode in, control word out
// Parameters:
//   OPCODE_W        : opcode width (>= 4)
//   HALT_ON_UNKNOWN : 1 = undefined opcode halts in T4, 0 = executes as NOP
// Build option: SAP_VARIABLE_CYCLE_EN shortens LDA to 5 clocks and OUT/NOP
// to 4 clocks by wrapping to T1 right after the last active T-state.
// The control word is a pure decode of (state, opcode); opcode only matters in T4..T6.
import sap_pkg::*;

module sap_controller #(
  parameter int OPCODE_W        = 4,
  parameter bit HALT_ON_UNKNOWN = 1'b0
) (
  input logic              clk,
  input logic              clr,
  sap_controller_if.master bus
);

  logic [5:0] t_state;
  logic       halted_q;
  logic       halt_req;

  logic is_lda, is_alu, is_out, is_hlt, is_unknown;
  logic t1, t2, t3, t4, t5, t6;

  assign t1 = t_state[0];
  assign t2 = t_state[1];
  assign t3 = t_state[2];
  assign t4 = t_state[3];
  assign t5 = t_state[4];
  assign t6 = t_state[5];

  assign is_lda = (bus.opcode == OPCODE_W'(OP_LDA));
  assign is_alu = (bus.opcode == OPCODE_W'(OP_ADD)) || (bus.opcode == OPCODE_W'(OP_SUB)) ||
                  (bus.opcode == OPCODE_W'(OP_AND)) || (bus.opcode == OPCODE_W'(OP_OR));
  assign is_out = (bus.opcode == OPCODE_W'(OP_OUT));
  assign is_hlt = (bus.opcode == OPCODE_W'(OP_HLT));
  assign is_unknown = !(is_lda || is_alu || is_out || is_hlt);

  assign halt_req = t4 && (is_hlt || (is_unknown && HALT_ON_UNKNOWN));

`ifdef SAP_VARIABLE_CYCLE_EN
  logic wrap_early;
  // LDA finishes in T5; OUT and a non-halting NOP finish in T4
  assign wrap_early = (t5 && is_lda) ||
                      (t4 && (is_out || (is_unknown && !HALT_ON_UNKNOWN)));
`endif

  sap_ring_counter u_ring (
    .clk        (clk),
    .clr        (clr),
    .halt_req   (halt_req),
`ifdef SAP_VARIABLE_CYCLE_EN
    .wrap_early (wrap_early),
`endif
    .t_state    (t_state),
    .halted     (halted_q)
  );

  // Each T-state enables at most one bus driver (ep, ce, ei, ea, eu).
  assign bus.t_state = t_state;
  assign bus.ep      = t1;
  assign bus.lm      = t1 || (t4 && (is_lda || is_alu));
  assign bus.cp      = t2;
  assign bus.ce      = t3 || (t5 && (is_lda || is_alu));
  assign bus.li      = t3;
  assign bus.ei      = t4 && (is_lda || is_alu);
  assign bus.ea      = t4 && is_out;
  assign bus.lo      = t4 && is_out;
  assign bus.la      = (t5 && is_lda) || (t6 && is_alu);
  assign bus.lb      = t5 && is_alu;
  assign bus.eu      = t6 && is_alu;
  assign bus.su      = (t6 && is_alu) ? alu_sel(4'(bus.opcode)) : SU_ADD;
  assign bus.halted  = halted_q || halt_req;

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed bench for sap_controller.
// Runs one DUT with HALT_ON_UNKNOWN=0 and one with HALT_ON_UNKNOWN=1 on the
// same clock, reset and opcode; expectations follow SAP_VARIABLE_CYCLE_EN.
`timescale 1ns/1ps
module tb_sap_controller;

  logic clk;
  logic clr;

  sap_controller_if #(.OPCODE_W(4)) bif ();
  sap_controller_if #(.OPCODE_W(4)) bif2 ();

  sap_controller #(.OPCODE_W(4), .HALT_ON_UNKNOWN(1'b0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif.master)
  );

  sap_controller #(.OPCODE_W(4), .HALT_ON_UNKNOWN(1'b1)) dut_halt (
    .clk (clk),
    .clr (clr),
    .bus (bif2.master)
  );

`ifdef SAP_VARIABLE_CYCLE_EN
  localparam bit VAR = 1'b1;
`else
  localparam bit VAR = 1'b0;
`endif

  // control word bit positions: {cp,ep,lm,ce,li,ei,la,ea,lb,eu,lo,halted,su[1:0]}
  localparam logic [13:0] CP = 14'h2000, EP = 14'h1000, LM = 14'h0800, CE = 14'h0400;
  localparam logic [13:0] LI = 14'h0200, EI = 14'h0100, LA = 14'h0080, EA = 14'h0040;
  localparam logic [13:0] LB = 14'h0020, EU = 14'h0010, LO = 14'h0008, HL = 14'h0004;
  localparam logic [5:0]  S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
  localparam logic [5:0]  S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000, SH = 6'b000000;

  logic [13:0] ctl1, ctl2;
  assign ctl1 = {bif.cp, bif.ep, bif.lm, bif.ce, bif.li, bif.ei, bif.la, bif.ea,
                 bif.lb, bif.eu, bif.lo, bif.halted, bif.su};
  assign ctl2 = {bif2.cp, bif2.ep, bif2.lm, bif2.ce, bif2.li, bif2.ei, bif2.la, bif2.ea,
                 bif2.lb, bif2.eu, bif2.lo, bif2.halted, bif2.su};

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op);
    bif.opcode  = op;
    bif2.opcode = op;
  endtask

  task automatic exp_st(input string tag, input logic [5:0] t, input logic [13:0] c);
    chk({tag, "_t"}, 32'(bif.t_state), 32'(t));
    chk({tag, "_ctl"}, 32'(ctl1), 32'(c));
    chk({tag, "_drv"}, 32'($countones({bif.ep, bif.ce, bif.ei, bif.ea, bif.eu}) <= 1), 32'd1);
  endtask

  task automatic exp_st2(input string tag, input logic [5:0] t, input logic [13:0] c);
    chk({tag, "_t2"}, 32'(bif2.t_state), 32'(t));
    chk({tag, "_ctl2"}, 32'(ctl2), 32'(c));
  endtask

  // fetch T1..T3 with an opcode that must be ignored, then present the real one
  task automatic fetch(input logic [3:0] fetch_op, input logic [3:0] op);
    set_op(fetch_op);
    exp_st("T1", S1, EP | LM); step();
    exp_st("T2", S2, CP);      step();
    exp_st("T3", S3, CE | LI);
    set_op(op);
    step();
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] fetch_op);
    logic [13:0] e4, e5, e6;
    int last;
    e4 = '0; e5 = '0; e6 = '0; last = 4;
    case (op)
      4'd0:                      begin e4 = EI | LM; e5 = CE | LA; last = 5; end
      4'd1, 4'd2, 4'd3, 4'd4:    begin e4 = EI | LM; e5 = CE | LB;
                                       e6 = EU | LA | 14'(op - 4'd1); last = 6; end
      4'd14:                     begin e4 = EA | LO; last = 4; end
      default:                   begin last = 4; end
    endcase
    fetch(fetch_op, op);
    exp_st($sformatf("op%0d_T4", op), S4, e4);
    if (op == 4'd9) exp_st2("nop_T4", S4, HL);
    step();
    if (op == 4'd9) exp_st2("nop_halt", SH, HL);
    if (!VAR || last >= 5) begin
      exp_st($sformatf("op%0d_T5", op), S5, e5); step();
    end
    if (!VAR || last >= 6) begin
      exp_st($sformatf("op%0d_T6", op), S6, e6); step();
    end
    exp_st($sformatf("op%0d_wrap", op), S1, EP | LM);
  endtask

  initial begin
    clr = 1'b1;
    set_op(4'd1);
    repeat (2) @(posedge clk);
    #1;
    exp_st("rst_hold", S1, EP | LM);
    exp_st2("rst_hold", S1, EP | LM);
    @(negedge clk);
    clr = 1'b0;
    #1;
    exp_st("rst_rel", S1, EP | LM);

    // ALU instructions
    run_instr(4'd1, 4'd1);
    run_instr(4'd2, 4'd2);
    run_instr(4'd3, 4'd3);
    run_instr(4'd4, 4'd4);
    // LDA with HLT on the opcode lines during fetch
    run_instr(4'd0, 4'd15);
    // OUT with junk opcode during fetch
    run_instr(4'd14, 4'd9);
    // undefined opcode: NOP here, HALT in dut_halt
    run_instr(4'd9, 4'd9);

    // HLT
    fetch(4'd15, 4'd15);
    exp_st("hlt_T4", S4, HL);
    step();
    for (int i = 0; i < 20; i++) begin
      set_op(4'(i));
      exp_st($sformatf("halt_%0d", i), SH, HL);
      exp_st2($sformatf("halt_%0d", i), SH, HL);
      step();
    end

    // clr pulse leaves HALT
    clr = 1'b1;
    #1;
    exp_st("hclr_async", S1, EP | LM);
    exp_st2("hclr_async", S1, EP | LM);
    #2;
    clr = 1'b0;
    #1;
    exp_st("hclr_rel", S1, EP | LM);
    step();
    exp_st("hclr_T2", S2, CP);
    exp_st2("hclr_T2", S2, CP);

    // reset in the middle of T5 of an ADD
    set_op(4'd1);
    step();
    exp_st("mid_T3", S3, CE | LI);
    step();
    exp_st("mid_T4", S4, EI | LM);
    step();
    exp_st("mid_T5", S5, CE | LB);
    #2;
    clr = 1'b1;
    #1;
    exp_st("mid_async", S1, EP | LM);
    step();
    exp_st("mid_hold", S1, EP | LM);
    #2;
    clr = 1'b0;
    #1;
    exp_st("mid_rel", S1, EP | LM);
    step();
    exp_st("mid_T2", S2, CP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
